read_merge_align: RTL and testbench

//  Read-return counterpart of the load/store input aligner. For one outstanding load, it

---
 rtl/read_merge_align.sv | 139 +++++++++++++
 tb/tb_read_merge_align.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_merge_align.sv
// Load-return aligner: collects one or two 16-byte lines for an outstanding load, merges them,
// rotates the requested bytes down to byte 0, zero-fills beyond the size and hands off with the tag.
module read_merge_align #(
  parameter int LINE_BYTES = 16,
  parameter int OUT_BYTES  = 8,
  parameter int TAG_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_needp1,
  input  logic [TAG_W-1:0]        req_tag,
  input  logic                    rsp0_valid,
  output logic                    rsp0_ready,
  input  logic [8*LINE_BYTES-1:0] rsp0_data,
  input  logic                    rsp1_valid,
  output logic                    rsp1_ready,
  input  logic [8*LINE_BYTES-1:0] rsp1_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*OUT_BYTES-1:0]  out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    err_unexp
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OUT_W  = 8 * OUT_BYTES;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  logic               r_got0, r_got1;
  logic [3:0]         r_addr;
  logic [1:0]         r_size;
  logic               r_needp1;
  logic [TAG_W-1:0]   r_tag;
  logic [LINE_W-1:0]  r_buf0, r_buf1;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_err;

  logic               w_cap0, w_cap1, w_got0, w_got1, w_done;
  logic [LINE_W-1:0]  w_line0, w_line1;
  logic [2*LINE_W-1:0] w_cat;
  logic [OUT_W-1:0]   w_shift, w_merged;
  logic [3:0]         w_nbytes;

  assign req_ready  = (r_state == S_IDLE);
  assign rsp0_ready = (r_state == S_WAIT) && !r_got0;
  assign rsp1_ready = (r_state == S_WAIT) && r_needp1 && !r_got1;

  assign w_cap0 = rsp0_valid && rsp0_ready;
  assign w_cap1 = rsp1_valid && rsp1_ready;
  assign w_got0 = r_got0 || w_cap0;
  assign w_got1 = r_got1 || w_cap1;
  assign w_done = (r_state == S_WAIT) && w_got0 && (w_got1 || !r_needp1);

  // Lines captured this cycle bypass the buffers so completion costs no extra cycle.
  assign w_line0  = w_cap0 ? rsp0_data : r_buf0;
  assign w_line1  = !r_needp1 ? '0 : (w_cap1 ? rsp1_data : r_buf1);
  assign w_cat    = {w_line1, w_line0};
  assign w_shift  = OUT_W'(w_cat >> {r_addr, 3'b000});
  assign w_nbytes = 4'd1 << r_size;

  always_comb begin
    w_merged = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      w_merged[8*k +: 8] = (4'(k) < w_nbytes) ? w_shift[8*k +: 8] : 8'h00;
    end
  end

  // NOTE: line buffers hold data only and are qualified by the got bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_cap0) r_buf0 <= rsp0_data;
    if (w_cap1) r_buf1 <= rsp1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_got0      <= 1'b0;
      r_got1      <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_needp1    <= 1'b0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= (rsp0_valid && !rsp0_ready) || (rsp1_valid && !rsp1_ready);
      if (flush) begin
        r_state     <= S_IDLE;
        r_got0      <= 1'b0;
        r_got1      <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: if (req_valid) begin
            r_addr   <= req_addr;
            r_size   <= req_size;
            r_needp1 <= req_needp1;
            r_tag    <= req_tag;
            r_got0   <= 1'b0;
            r_got1   <= 1'b0;
            r_state  <= S_WAIT;
          end
          S_WAIT: begin
            if (w_cap0) r_got0 <= 1'b1;
            if (w_cap1) r_got1 <= 1'b1;
            if (w_done) begin
              r_out_data  <= w_merged;
              r_out_tag   <= r_tag;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          S_DONE: if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign err_unexp = r_err;

endmodule

// File: tb/tb_read_merge_align.sv
// Self-checking bench for read_merge_align: directed corner cases plus randomized loads checked
// against a byte-array reference model.
module tb_read_merge_align;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_addr;
  logic [1:0]   req_size;
  logic         req_needp1;
  logic [6:0]   req_tag;
  logic         rsp0_valid, rsp0_ready;
  logic [127:0] rsp0_data;
  logic         rsp1_valid, rsp1_ready;
  logic [127:0] rsp1_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [6:0]   out_tag;
  logic         err_unexp;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [63:0]  exp_data;
  logic [6:0]   exp_tag;

  read_merge_align dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
    .req_needp1(req_needp1), .req_tag(req_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: lay the two lines out as a 32-byte array and pick bytes addr..addr+n-1.
  function automatic logic [63:0] model(input logic [3:0] a, input logic [1:0] s, input logic np,
                                        input logic [127:0] l0, input logic [127:0] l1);
    logic [7:0]  bytes [32];
    logic [63:0] res = '0;
    int          n   = 1 << s;
    for (int i = 0; i < 16; i++) begin
      bytes[i]      = l0[8*i +: 8];
      bytes[16 + i] = np ? l1[8*i +: 8] : 8'h00;
    end
    for (int k = 0; k < n; k++) res[8*k +: 8] = bytes[int'(a) + k];
    return res;
  endfunction

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = base + 8'(i);
    return v;
  endfunction

  // Issue a request and deliver responses at relative cycles d0/d1; checks the result latency.
  task automatic fill(input logic [3:0] a, input logic [1:0] s, input logic np, input logic [6:0] tag,
                      input logic [127:0] l0, input logic [127:0] l1, input int d0, input int d1);
    int last;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_addr = a; req_size = s; req_needp1 = np; req_tag = tag;
    @(negedge clk);
    req_valid = 1'b0;
    last = (np && d1 > d0) ? d1 : d0;
    for (int c = 0; c <= last; c++) begin
      check("wait_no_valid", {63'd0, out_valid}, 64'd0);
      rsp0_valid = (c == d0);
      rsp0_data  = l0;
      rsp1_valid = np && (c == d1);
      rsp1_data  = l1;
      @(negedge clk);
    end
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    exp_data = model(a, s, np, l0, l1);
    exp_tag  = tag;
    check("out_valid_rise", {63'd0, out_valid}, 64'd1);
    check("out_data", out_data, exp_data);
    check("out_tag", {57'd0, out_tag}, {57'd0, exp_tag});
    check("no_err", {63'd0, err_unexp}, 64'd0);
  endtask

  task automatic drain(input int stall);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", out_data, exp_data);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept_valid_low", {63'd0, out_valid}, 64'd0);
    check("accept_idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [127:0] l0, l1;
    logic [3:0]   a;
    logic [1:0]   s;
    logic         np;

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0;
    req_needp1 = 1'b0; req_tag = '0; rsp0_valid = 1'b0; rsp0_data = '0;
    rsp1_valid = 1'b0; rsp1_data = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", {57'd0, out_tag}, 64'd0);
    check("rst_err", {63'd0, err_unexp}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_ready", {62'd0, rsp0_ready, rsp1_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    fill(4'h0, 2'b11, 1'b0, 7'h11, ramp(8'h00), ramp(8'h10), 0, 0);
    check("dir_full8", out_data, 64'h0706050403020100);
    drain(0);
    fill(4'hE, 2'b10, 1'b1, 7'h5A, ramp(8'h00), ramp(8'h10), 2, 0);
    check("dir_cross4", out_data, 64'h0000_0000_1110_0F0E);
    drain(1);
    fill(4'hF, 2'b01, 1'b1, 7'h23, ramp(8'h00), ramp(8'h10), 0, 0);
    check("dir_cross2", out_data, 64'h100F);
    drain(0);
    fill(4'h3, 2'b00, 1'b0, 7'h7F, ramp(8'h00), ramp(8'h10), 1, 0);
    check("dir_byte", out_data, 64'h03);
    drain(5);

    // Response while idle
    rsp0_valid = 1'b1;
    @(negedge clk);
    rsp0_valid = 1'b0;
    check("err_idle", {63'd0, err_unexp}, 64'd1);
    @(negedge clk);
    check("err_idle_clear", {63'd0, err_unexp}, 64'd0);

    // Duplicate rsp0 while waiting on line 1
    req_valid = 1'b1; req_addr = 4'hC; req_size = 2'b11; req_needp1 = 1'b1; req_tag = 7'h42;
    @(negedge clk);
    req_valid = 1'b0;
    rsp0_valid = 1'b1; rsp0_data = ramp(8'h40);
    @(negedge clk);
    rsp0_data = ramp(8'hA0);
    @(negedge clk);
    rsp0_valid = 1'b0;
    check("err_dup0", {63'd0, err_unexp}, 64'd1);
    check("dup0_no_valid", {63'd0, out_valid}, 64'd0);
    rsp1_valid = 1'b1; rsp1_data = ramp(8'h80);
    @(negedge clk);
    rsp1_valid = 1'b0;
    exp_data = model(4'hC, 2'b11, 1'b1, ramp(8'h40), ramp(8'h80));
    check("dup0_err_clear", {63'd0, err_unexp}, 64'd0);
    check("dup0_valid", {63'd0, out_valid}, 64'd1);
    check("dup0_data", out_data, exp_data);
    drain(0);

    // rsp1 when no line 1 is expected
    req_valid = 1'b1; req_addr = 4'h2; req_size = 2'b10; req_needp1 = 1'b0; req_tag = 7'h09;
    @(negedge clk);
    req_valid = 1'b0;
    rsp1_valid = 1'b1; rsp1_data = ramp(8'hF0);
    @(negedge clk);
    rsp1_valid = 1'b0;
    check("err_rsp1_np0", {63'd0, err_unexp}, 64'd1);
    check("np0_no_valid", {63'd0, out_valid}, 64'd0);
    rsp0_valid = 1'b1; rsp0_data = ramp(8'h30);
    @(negedge clk);
    rsp0_valid = 1'b0;
    check("np0_valid", {63'd0, out_valid}, 64'd1);
    check("np0_data", out_data, 64'h3532_3433 & 64'h0 | 64'h35343332);
    exp_data = 64'h35343332;
    drain(0);

    // Flush after line 0 captured, with a request offered in the same cycle
    req_valid = 1'b1; req_addr = 4'h9; req_size = 2'b11; req_needp1 = 1'b1; req_tag = 7'h01;
    @(negedge clk);
    req_valid = 1'b0;
    rsp0_valid = 1'b1; rsp0_data = ramp(8'h55);
    @(negedge clk);
    rsp0_valid = 1'b0;
    flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check("flush_idle", {63'd0, req_ready}, 64'd1);
    check("flush_no_valid", {63'd0, out_valid}, 64'd0);
    fill(4'h9, 2'b11, 1'b1, 7'h02, ramp(8'h60), ramp(8'h70), 2, 0);
    drain(0);

    // Async reset while holding a result
    fill(4'h5, 2'b10, 1'b0, 7'h33, ramp(8'hC0), ramp(8'hD0), 0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", {63'd0, out_valid}, 64'd0);
    check("rst_done_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_idle", {63'd0, req_ready}, 64'd1);
    fill(4'h1, 2'b01, 1'b0, 7'h44, ramp(8'h20), ramp(8'h30), 1, 0);
    check("post_rst_data", out_data, 64'h2221);
    drain(0);

    // Randomized loads
    for (int t = 0; t < 40; t++) begin
      a  = 4'($urandom_range(0, 15));
      s  = 2'($urandom_range(0, 3));
      np = (int'(a) + (1 << s) > 16) ? 1'b1 : 1'($urandom_range(0, 1));
      l0 = {$urandom, $urandom, $urandom, $urandom};
      l1 = {$urandom, $urandom, $urandom, $urandom};
      fill(a, s, np, 7'($urandom), l0, l1, $urandom_range(0, 3), $urandom_range(0, 3));
      drain($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
